// File: rtl/gray_share_arbiter.sv
// Round-robin burst arbiter sharing one RGB888->gray converter between NCH pixel streams.
// Every beat is tagged with its channel so the converter result is routed back to its origin.
module gray_share_arbiter #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned BURST_LEN = 640,
  parameter int unsigned CONV_LAT  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH*24-1:0] s_data_i,
  input  logic [NCH-1:0]    s_valid_i,
  input  logic [NCH-1:0]    s_last_i,
  output logic [NCH-1:0]    s_ready_o,
  output logic [23:0]       conv_data_o,
  output logic              conv_valid_o,
  input  logic [7:0]        conv_gray_i,
  input  logic              conv_gray_vld_i,
  output logic [7:0]        m_gray_o,
  output logic [NCH-1:0]    m_valid_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              err_sync_o
);
  localparam int unsigned ChW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned MskW = $clog2(CONV_LAT + 1);

  localparam logic [ChW-1:0]  LastCh  = ChW'(NCH - 1);
  localparam logic [ChW:0]    NchExt  = (ChW + 1)'(NCH);
  localparam logic [CntW-1:0] CntMax  = CntW'(BURST_LEN - 1);
  localparam logic [MskW-1:0] MskInit = MskW'(CONV_LAT);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  typedef struct packed {
    logic           vld;
    logic [ChW-1:0] ch;
    logic           last;
  } tag_t;

  function automatic logic [NCH-1:0] to_onehot(input logic [ChW-1:0] idx);
    logic [NCH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_e          state_q, state_d;
  logic [ChW-1:0]  gnt_q, gnt_d;
  logic [ChW-1:0]  rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [23:0]     conv_data_q;
  logic            conv_valid_q;
  logic [ChW-1:0]  tag_ch_q;
  logic            tag_last_q;
  tag_t            pipe_q [CONV_LAT];
  tag_t            tag_in, tag_out;
  logic            pipe_busy;

  logic [7:0]      m_gray_q;
  logic [NCH-1:0]  m_valid_q;
  logic            m_last_q;
  logic            err_q;
  logic [MskW-1:0] mask_q;

  logic            any_req;
  logic [ChW-1:0]  pick;
  logic [ChW:0]    cand;
  logic [23:0]     sel_data;
  logic            sel_valid, sel_last;
  logic            beat, end_burst;

  // First requester strictly after the rr pointer, wrapping; rr itself is checked last.
  always_comb begin
    any_req = 1'b0;
    pick    = rr_q;
    cand    = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = {1'b0, rr_q} + (ChW + 1)'(k);
      if (cand >= NchExt) cand = cand - NchExt;
      if (!any_req && s_valid_i[cand[ChW-1:0]]) begin
        any_req = 1'b1;
        pick    = cand[ChW-1:0];
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_q == ChW'(i)) begin
        sel_data  = s_data_i[24*i +: 24];
        sel_valid = s_valid_i[i];
        sel_last  = s_last_i[i];
      end
    end
  end

  assign s_ready_o = (state_q == StGrant) ? to_onehot(gnt_q) : '0;
  assign beat      = (state_q == StGrant) & sel_valid;
  assign end_burst = beat & (sel_last | (cnt_q == CntMax));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StGrant;
          gnt_d   = pick;
          rr_d    = pick;
          cnt_d   = '0;
        end
      end
      StGrant: begin
        if (beat) begin
          cnt_d = cnt_q + CntW'(1);
          if (end_burst) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= LastCh;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conv_valid_q <= 1'b0;
      conv_data_q  <= '0;
      tag_ch_q     <= '0;
      tag_last_q   <= 1'b0;
    end else begin
      conv_valid_q <= beat;
      if (beat) begin
        conv_data_q <= sel_data;
        tag_ch_q    <= gnt_q;
        tag_last_q  <= sel_last;
      end
    end
  end

  // Tag pipe mirrors the converter latency so its head lines up with conv_gray_vld_i.
  always_comb begin
    tag_in.vld  = conv_valid_q;
    tag_in.ch   = tag_ch_q;
    tag_in.last = conv_valid_q & tag_last_q;
    tag_out     = pipe_q[CONV_LAT-1];
    pipe_busy   = 1'b0;
    for (int unsigned i = 0; i < CONV_LAT; i++) begin
      pipe_busy = pipe_busy | pipe_q[i].vld;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < CONV_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < CONV_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // The converter is not reset, so its outputs for beats dropped by rst are ignored for
  // CONV_LAT cycles rather than flagged as a sync error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_gray_q  <= '0;
      m_valid_q <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
      mask_q    <= MskInit;
    end else begin
      if (mask_q != '0) mask_q <= mask_q - MskW'(1);
      if (conv_gray_vld_i) begin
        m_gray_q  <= conv_gray_i;
        m_valid_q <= tag_out.vld ? to_onehot(tag_out.ch) : '0;
        m_last_q  <= tag_out.last;
      end else begin
        m_valid_q <= '0;
        m_last_q  <= 1'b0;
      end
      if ((conv_gray_vld_i != tag_out.vld) && (mask_q == '0)) err_q <= 1'b1;
    end
  end

  assign conv_data_o  = conv_data_q;
  assign conv_valid_o = conv_valid_q;
  assign m_gray_o     = m_gray_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;
  assign err_sync_o   = err_q;
  assign busy_o       = (state_q == StGrant) | conv_valid_q | pipe_busy | (|m_valid_q);

endmodule

// File: tb/tb_gray_share_arbiter.sv
// Directed bench for gray_share_arbiter: two instances (default burst length and BURST_LEN=4)
// share one stimulus bus, each with its own 2-cycle converter model.
module tb_gray_share_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] s_data = '0;
  logic [1:0]  s_valid = '0;
  logic [1:0]  s_last = '0;

  logic [1:0]  s_ready_a, s_ready_b;
  logic [23:0] cd_a, cd_b;
  logic        cv_a, cv_b;
  logic [7:0]  cg_a = '0, cg_b = '0, cg_p_a = '0, cg_p_b = '0;
  logic        cgv_a = 1'b0, cgv_b = 1'b0, cv_p_a = 1'b0, cv_p_b = 1'b0;
  logic [7:0]  mg_a, mg_b;
  logic [1:0]  mv_a, mv_b;
  logic        ml_a, ml_b, busy_a, busy_b, err_a, err_b;

  always #5 clk = ~clk;

  gray_share_arbiter #(.NCH(2), .BURST_LEN(640), .CONV_LAT(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
    .s_ready_o(s_ready_a), .conv_data_o(cd_a), .conv_valid_o(cv_a), .conv_gray_i(cg_a),
    .conv_gray_vld_i(cgv_a), .m_gray_o(mg_a), .m_valid_o(mv_a), .m_last_o(ml_a),
    .busy_o(busy_a), .err_sync_o(err_a)
  );

  gray_share_arbiter #(.NCH(2), .BURST_LEN(4), .CONV_LAT(2)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
    .s_ready_o(s_ready_b), .conv_data_o(cd_b), .conv_valid_o(cv_b), .conv_gray_i(cg_b),
    .conv_gray_vld_i(cgv_b), .m_gray_o(mg_b), .m_valid_o(mv_b), .m_last_o(ml_b),
    .busy_o(busy_b), .err_sync_o(err_b)
  );

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    logic [31:0] s;
    s = 77 * p[23:16] + 150 * p[15:8] + 29 * p[7:0];
    return s[15:8];
  endfunction

  // Converter models: no reset, fixed 2-cycle latency.
  always @(posedge clk) begin
    cv_p_a <= cv_a;  cg_p_a <= gray_of(cd_a);  cgv_a <= cv_p_a;  cg_a <= cg_p_a;
    cv_p_b <= cv_b;  cg_p_b <= gray_of(cd_b);  cgv_b <= cv_p_b;  cg_b <= cg_p_b;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus engine state
  logic        use_b, rst_req;
  int          cyc;
  int          n_px [2], sent [2], line_len [2], start [2];
  logic [1:0]  gap, hold_off;
  logic [23:0] pix_tab [2][16];

  // Logs
  int          n_hs, n_out;
  int          hs_cyc [64], hs_ch [64], out_cyc [64];
  logic        hs_last [64], out_last [64];
  logic [1:0]  out_vld [64], rdy_log [64];
  logic [7:0]  out_gray [64];
  logic        busy_log [64];
  int          exp3 [10] = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
  logic [7:0]  lastvec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic setup(input logic sel_b);
    use_b = sel_b; rst_req = 1'b0; cyc = 0; n_hs = 0; n_out = 0;
    gap = '0; hold_off = '0;
    for (int c = 0; c < 2; c++) begin
      sent[c] = 0; n_px[c] = 0; line_len[c] = 0; start[c] = 0;
    end
    for (int k = 0; k < 64; k++) begin
      rdy_log[k] = '0; busy_log[k] = 1'b0;
    end
  endtask

  task automatic step();
    logic [1:0] rdy, mv;
    logic       v;
    @(posedge clk);
    #1;
    rst = rst_req;
    for (int c = 0; c < 2; c++) begin
      v = (sent[c] < n_px[c]) && !hold_off[c] && (cyc >= start[c]);
      s_valid[c] = v;
      s_data[24*c +: 24] = pix_tab[c][sent[c] % 16];
      s_last[c] = v && (line_len[c] != 0) && (((sent[c] + 1) % line_len[c]) == 0);
    end
    @(negedge clk);
    rdy = use_b ? s_ready_b : s_ready_a;
    mv  = use_b ? mv_b : mv_a;
    if (cyc < 64) begin
      rdy_log[cyc]  = rdy;
      busy_log[cyc] = use_b ? busy_b : busy_a;
    end
    for (int c = 0; c < 2; c++) begin
      if (s_valid[c] && rdy[c]) begin
        if (n_hs < 64) begin
          hs_cyc[n_hs] = cyc; hs_ch[n_hs] = c; hs_last[n_hs] = s_last[c];
          n_hs++;
        end
        sent[c]++;
        hold_off[c] = gap[c];
      end else begin
        hold_off[c] = 1'b0;
      end
    end
    if (mv != '0 && n_out < 64) begin
      out_cyc[n_out]  = cyc;
      out_vld[n_out]  = mv;
      out_last[n_out] = use_b ? ml_b : ml_a;
      out_gray[n_out] = use_b ? mg_b : mg_a;
      n_out++;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      pix_tab[0][k] = 24'h204080 + 24'(k);
      pix_tab[1][k] = 24'h801040 + 24'(k);
    end

    // Reset values
    do_reset();
    chk("rst_s_ready", {30'd0, s_ready_a}, 32'd0);
    chk("rst_s_ready_b", {30'd0, s_ready_b}, 32'd0);
    chk("rst_conv_valid", {31'd0, cv_a}, 32'd0);
    chk("rst_conv_data", {8'd0, cd_a}, 32'd0);
    chk("rst_m_valid", {30'd0, mv_a}, 32'd0);
    chk("rst_m_gray", {24'd0, mg_a}, 32'd0);
    chk("rst_m_last", {31'd0, ml_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);

    // 1: single ch0 line of 8 px
    setup(1'b0);
    n_px[0] = 8; line_len[0] = 8;
    run(16);
    chk("t1_n_hs", n_hs, 8);
    chk("t1_first_accept", hs_cyc[0], 1);
    chk("t1_last_accept", hs_cyc[7], 8);
    chk("t1_n_out", n_out, 8);
    lastvec = '0;
    for (int k = 0; k < 8; k++) begin
      chk("t1_m_valid", {30'd0, out_vld[k]}, 32'd1);
      chk("t1_out_cyc", out_cyc[k], 5 + k);
      lastvec[k] = out_last[k];
    end
    chk("t1_m_last_vec", {24'd0, lastvec}, 32'h80);
    chk("t1_busy_tail", {31'd0, busy_log[12]}, 32'd1);
    chk("t1_busy_done", {31'd0, busy_log[13]}, 32'd0);
    chk("t1_err", {31'd0, err_a}, 32'd0);

    // 2: both channels always valid, 4-px lines, two lines each
    do_reset();
    setup(1'b0);
    n_px[0] = 8; n_px[1] = 8; line_len[0] = 4; line_len[1] = 4;
    run(26);
    chk("t2_n_hs", n_hs, 16);
    chk("t2_n_out", n_out, 16);
    for (int k = 0; k < 16; k++) begin
      chk("t2_gnt_ch", hs_ch[k], (k / 4) % 2);
      chk("t2_hs_cyc", hs_cyc[k], 1 + 5 * (k / 4) + k % 4);
      chk("t2_m_valid", {30'd0, out_vld[k]}, ((k / 4) % 2) ? 32'd2 : 32'd1);
      chk("t2_out_cyc", out_cyc[k], 5 + 5 * (k / 4) + k % 4);
      chk("t2_m_last", {31'd0, out_last[k]}, (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    chk("t2_bubble", {30'd0, rdy_log[5]}, 32'd0);

    // 3: BURST_LEN=4, ch0 sends 10 px with no s_last
    do_reset();
    setup(1'b1);
    n_px[0] = 10;
    run(20);
    chk("t3_n_hs", n_hs, 10);
    for (int k = 0; k < 10; k++) chk("t3_hs_cyc", hs_cyc[k], exp3[k]);
    chk("t3_rdy_beat4", {30'd0, rdy_log[4]}, 32'd1);
    chk("t3_rdy_gap1", {30'd0, rdy_log[5]}, 32'd0);
    chk("t3_rdy_gap2", {30'd0, rdy_log[10]}, 32'd0);
    chk("t3_rdy_regrant", {30'd0, rdy_log[11]}, 32'd1);
    chk("t3_n_out", n_out, 10);
    chk("t3_no_last", {31'd0, out_last[3] | out_last[7] | out_last[9]}, 32'd0);
    chk("t3_err", {31'd0, err_b}, 32'd0);

    // 3b: BURST_LEN=4 with s_last on the 4th beat ends the burst once
    do_reset();
    setup(1'b1);
    n_px[0] = 8; line_len[0] = 4;
    run(16);
    chk("t3b_n_hs", n_hs, 8);
    chk("t3b_hs4", hs_cyc[4], 6);
    chk("t3b_hs7", hs_cyc[7], 9);
    chk("t3b_n_out", n_out, 8);
    chk("t3b_last3", {31'd0, out_last[3]}, 32'd1);
    chk("t3b_last4", {31'd0, out_last[4]}, 32'd0);
    chk("t3b_last7", {31'd0, out_last[7]}, 32'd1);

    // 4: ch1 with gaps holds the grant while ch0 waits
    do_reset();
    setup(1'b0);
    n_px[1] = 4; line_len[1] = 4; gap[1] = 1'b1;
    n_px[0] = 4; line_len[0] = 4; start[0] = 2;
    run(20);
    chk("t4_n_hs", n_hs, 8);
    for (int k = 0; k < 4; k++) begin
      chk("t4_ch1_hs_ch", hs_ch[k], 1);
      chk("t4_ch1_hs_cyc", hs_cyc[k], 1 + 2 * k);
      chk("t4_ch0_hs_ch", hs_ch[4 + k], 0);
      chk("t4_ch0_hs_cyc", hs_cyc[4 + k], 9 + k);
    end
    for (int k = 0; k < 9; k++) chk("t4_ch0_rdy_low", {31'd0, rdy_log[k][0]}, 32'd0);
    chk("t4_gap_rdy", {30'd0, rdy_log[2]}, 32'd2);
    chk("t4_n_out", n_out, 8);
    chk("t4_out0", {30'd0, out_vld[0]}, 32'd2);
    chk("t4_out3_cyc", out_cyc[3], 11);
    chk("t4_out3_last", {31'd0, out_last[3]}, 32'd1);
    chk("t4_out4", {30'd0, out_vld[4]}, 32'd1);
    chk("t4_out7_cyc", out_cyc[7], 16);
    chk("t4_out7_last", {31'd0, out_last[7]}, 32'd1);

    // 5: gray values routed to the right channel
    do_reset();
    setup(1'b0);
    pix_tab[0][0] = 24'hFF0000; pix_tab[0][1] = 24'h0000FF;
    pix_tab[1][0] = 24'h00FF00; pix_tab[1][1] = 24'hFFFFFF;
    n_px[0] = 2; n_px[1] = 2; line_len[0] = 2; line_len[1] = 2;
    run(12);
    chk("t5_n_out", n_out, 4);
    chk("t5_red_gray", {24'd0, out_gray[0]}, 32'd76);
    chk("t5_red_ch", {30'd0, out_vld[0]}, 32'd1);
    chk("t5_blue_gray", {24'd0, out_gray[1]}, 32'd28);
    chk("t5_blue_ch", {30'd0, out_vld[1]}, 32'd1);
    chk("t5_green_gray", {24'd0, out_gray[2]}, 32'd149);
    chk("t5_green_ch", {30'd0, out_vld[2]}, 32'd2);
    chk("t5_white_gray", {24'd0, out_gray[3]}, 32'd255);
    chk("t5_white_ch", {30'd0, out_vld[3]}, 32'd2);
    chk("t5_white_cyc", out_cyc[3], 9);

    // 6: rst one cycle after 3 accepted beats drops in-flight data
    do_reset();
    setup(1'b0);
    n_px[0] = 8; line_len[0] = 8;
    run(4);
    chk("t6_pre_hs", n_hs, 3);
    n_px[0] = sent[0];
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    run(6);
    chk("t6_no_m_valid", n_out, 0);
    chk("t6_busy_after_rst", {31'd0, busy_log[5]}, 32'd0);
    chk("t6_err", {31'd0, err_a}, 32'd0);

    setup(1'b0);
    n_px[0] = 2; n_px[1] = 2; line_len[0] = 2; line_len[1] = 2;
    run(10);
    chk("t6_tie_first", hs_ch[0], 0);
    chk("t6_tie_first_cyc", hs_cyc[0], 1);
    chk("t6_tie_second", hs_ch[2], 1);
    chk("t6_tie_second_cyc", hs_cyc[2], 4);

    setup(1'b0);
    n_px[1] = 2; line_len[1] = 2;
    run(8);
    chk("t6_alone_n", n_hs, 2);
    chk("t6_alone_ch", hs_ch[0], 1);
    chk("t6_alone_cyc", hs_cyc[0], 1);
    chk("t6_final_err", {31'd0, err_a}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
